// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
// Holds the controller state encoding and address-width helper.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD_W,
      SWITCH,
      COMPUTE,
      DRAIN,
      DONE
   } ctrl_state_t;

   localparam int BUF_RD_LAT = 1;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/skew_delay.sv
// Bank of N single-bit shift lines; line i delays d by BASE+i cycles.
// Ports: clk, rst_n (async active-low), d (shared input), q[N] (taps).
module skew_delay #(
   parameter int N    = 4,
   parameter int BASE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         d,
   output logic [N-1:0] q
);

   for (genvar i = 0; i < N; i++) begin : g_line
      localparam int D = BASE + i;
      if (D == 0) begin : g_wire
         assign q[i] = d;
      end else if (D == 1) begin : g_one
         logic r;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r <= 1'b0;
            else        r <= d;
         end
         assign q[i] = r;
      end else begin : g_sr
         logic [D-1:0] sr;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else        sr <= {sr[D-2:0], d};
         end
         assign q[i] = sr[D-1];
      end
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Run sequencer for an NxN weight-stationary systolic array.
// Ports: clk, rst_n, start/reuse_w/num_vecs in; busy, done, pe_enabled,
// weight/input buffer reads, accept_w, row_switch, row_valid, col_out_valid.
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int N     = 4,
   parameter int VEC_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 reuse_w,
   input  logic [VEC_W-1:0]     num_vecs,
   output logic                 busy,
   output logic                 done,
   output logic                 pe_enabled,
   output logic                 w_rd_en,
   output logic [$clog2(N)-1:0] w_rd_addr,
   output logic [N-1:0]         accept_w,
   output logic                 in_rd_en,
   output logic [VEC_W-1:0]     in_rd_addr,
   output logic [N-1:0]         row_switch,
   output logic [N-1:0]         row_valid,
   output logic [N-1:0]         col_out_valid
);

   localparam int AW = addr_w(N);
   localparam logic [VEC_W-1:0] ONE    = VEC_W'(1);
   localparam logic [VEC_W-1:0] LAST_L = VEC_W'(N);
   localparam logic [VEC_W-1:0] LAST_R = VEC_W'(N - 1);
   localparam logic [VEC_W-1:0] LAST_D = VEC_W'(2 * N - 1);

   ctrl_state_t      state;
   logic [VEC_W-1:0] cnt;
   logic [VEC_W-1:0] m_last;
   logic             switch_base;
   logic             valid_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         m_last      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pe_enabled  <= 1'b1;
         w_rd_en     <= 1'b0;
         w_rd_addr   <= '0;
         accept_w    <= '0;
         in_rd_en    <= 1'b0;
         in_rd_addr  <= '0;
         switch_base <= 1'b0;
         valid_base  <= 1'b0;
      end else begin
         done        <= 1'b0;
         pe_enabled  <= 1'b1;
         w_rd_en     <= 1'b0;
         accept_w    <= '0;
         in_rd_en    <= 1'b0;
         switch_base <= 1'b0;
         // input buffer data lands one cycle after the read strobe
         valid_base  <= in_rd_en;
         unique case (state)
            IDLE: begin
               if (start && num_vecs != '0) begin
                  m_last <= num_vecs - ONE;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  if (reuse_w) begin
                     state      <= COMPUTE;
                     in_rd_en   <= 1'b1;
                     in_rd_addr <= '0;
                  end else begin
                     state      <= CLEAR;
                     pe_enabled <= 1'b0;
                  end
               end
            end
            CLEAR: begin
               state     <= LOAD_W;
               cnt       <= '0;
               w_rd_en   <= 1'b1;
               w_rd_addr <= '0;
            end
            LOAD_W: begin
               if (cnt == LAST_L) begin
                  state       <= SWITCH;
                  switch_base <= 1'b1;
               end else begin
                  cnt       <= cnt + ONE;
                  // accept trails the read strobe by the buffer latency
                  accept_w  <= {N{w_rd_en}};
                  w_rd_en   <= (cnt < LAST_R);
                  w_rd_addr <= AW'(cnt + ONE);
               end
            end
            SWITCH: begin
               state      <= COMPUTE;
               cnt        <= '0;
               in_rd_en   <= 1'b1;
               in_rd_addr <= '0;
            end
            COMPUTE: begin
               if (cnt == m_last) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt        <= cnt + ONE;
                  in_rd_en   <= 1'b1;
                  in_rd_addr <= cnt + ONE;
               end
            end
            DRAIN: begin
               if (cnt == LAST_D) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   skew_delay #(.N(N), .BASE(0)) u_sw_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (switch_base),
      .q     (row_switch)
   );

   skew_delay #(.N(N), .BASE(0)) u_vld_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (valid_base),
      .q     (row_valid)
   );

   // bottom row of column c sees its data N+c cycles after valid_base
   skew_delay #(.N(N), .BASE(N)) u_out_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (valid_base),
      .q     (col_out_valid)
   );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl with a behavioural PE array model.
// Checks every control output per cycle and end-to-end south-edge psums.
module tb_systolic_ctrl;

   localparam int N  = 4;
   localparam int VW = 16;
   localparam int AW = $clog2(N);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          reuse_w;
   logic [VW-1:0] num_vecs;
   logic          busy;
   logic          done;
   logic          pe_enabled;
   logic          w_rd_en;
   logic [AW-1:0] w_rd_addr;
   logic [N-1:0]  accept_w;
   logic          in_rd_en;
   logic [VW-1:0] in_rd_addr;
   logic [N-1:0]  row_switch;
   logic [N-1:0]  row_valid;
   logic [N-1:0]  col_out_valid;

   systolic_ctrl #(.N(N), .VEC_W(VW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .reuse_w       (reuse_w),
      .num_vecs      (num_vecs),
      .busy          (busy),
      .done          (done),
      .pe_enabled    (pe_enabled),
      .w_rd_en       (w_rd_en),
      .w_rd_addr     (w_rd_addr),
      .accept_w      (accept_w),
      .in_rd_en      (in_rd_en),
      .in_rd_addr    (in_rd_addr),
      .row_switch    (row_switch),
      .row_valid     (row_valid),
      .col_out_valid (col_out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          pe_en;
      logic          w_en;
      logic [AW-1:0] w_addr;
      logic [N-1:0]  acc;
      logic          in_en;
      logic [VW-1:0] in_addr;
      logic [N-1:0]  rsw;
      logic [N-1:0]  rv;
      logic [N-1:0]  cov;
   } obs_t;

   obs_t exp_q[$];
   int   ps_q[N][$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 0;
   bit   e2e    = 0;

   function automatic obs_t idle_obs();
      obs_t o;
      o       = '0;
      o.pe_en = 1'b1;
      return o;
   endfunction

   // Expected outputs t cycles after the start-sampling edge.
   function automatic obs_t exp_at(int t, int m, bit reuse);
      obs_t o;
      int   c0;
      int   d;
      o  = '0;
      c0 = reuse ? 1 : N + 4;
      d  = c0 + m + 2 * N;
      o.pe_en = !(!reuse && t == 1);
      o.busy  = (t >= 1 && t <= d);
      o.done  = (t == d);
      if (!reuse && t >= 2 && t <= N + 1) begin
         o.w_en   = 1'b1;
         o.w_addr = AW'(t - 2);
      end
      if (!reuse && t >= 3 && t <= N + 2) o.acc = '1;
      if (t >= c0 && t < c0 + m) begin
         o.in_en   = 1'b1;
         o.in_addr = VW'(t - c0);
      end
      for (int r = 0; r < N; r++) begin
         o.rsw[r] = !reuse && (t == N + 3 + r);
         o.rv[r]  = (t >= c0 + 1 + r) && (t <= c0 + m + r);
         o.cov[r] = (t >= c0 + 1 + N + r) && (t <= c0 + m + N + r);
      end
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.busy    = busy;
      o.done    = done;
      o.pe_en   = pe_enabled;
      o.w_en    = w_rd_en;
      o.w_addr  = w_rd_addr;
      o.acc     = accept_w;
      o.in_en   = in_rd_en;
      o.in_addr = in_rd_addr;
      o.rsw     = row_switch;
      o.rv      = row_valid;
      o.cov     = col_out_valid;
      return o;
   endfunction

   always @(negedge clk) begin
      obs_t e;
      obs_t a;
      if (mon_en && rst_n) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
         a = sample();
         if (!e.w_en)  a.w_addr  = '0;
         if (!e.in_en) a.in_addr = '0;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL ctrl_outputs t=%0t got %h exp %h", $time, a, e);
         end
      end
   end

   // ---------------- buffer and PE array model ----------------
   int   wbuf[N][N];
   int   ibuf[8][N];
   int   w_data[N];
   int   in_data[N];
   int   dsk[N][N];
   int   sh[N][N];
   int   act[N][N];
   int   ps[N][N];
   int   a_reg[N][N];
   bit   v_reg[N][N];
   bit   s_reg[N][N];

   always @(posedge clk) begin
      if (w_rd_en)
         for (int c = 0; c < N; c++) w_data[c] <= wbuf[w_rd_addr][c];
      if (in_rd_en)
         for (int c = 0; c < N; c++) in_data[c] <= ibuf[in_rd_addr[2:0]][c];
      for (int r = 0; r < N; r++) begin
         dsk[r][0] <= in_data[r];
         for (int k = 1; k < N; k++) dsk[r][k] <= dsk[r][k-1];
      end
   end

   always @(posedge clk) begin
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            bit vin;
            bit sin;
            int ain;
            int pin;
            if (c == 0) begin
               vin = row_valid[r];
               sin = row_switch[r];
               ain = (r == 0) ? in_data[0] : dsk[r][r-1];
            end else begin
               vin = v_reg[r][c-1];
               sin = s_reg[r][c-1];
               ain = a_reg[r][c-1];
            end
            pin = (r == 0) ? 0 : ps[r-1][c];
            if (!pe_enabled) begin
               sh[r][c]  <= 0;
               act[r][c] <= 0;
            end else begin
               if (accept_w[c])
                  sh[r][c] <= (r == 0) ? w_data[c] : sh[r-1][c];
               if (sin) act[r][c] <= sh[r][c];
            end
            v_reg[r][c] <= vin;
            s_reg[r][c] <= sin;
            a_reg[r][c] <= ain;
            if (vin) ps[r][c] <= pin + ((act[r][c] * ain) >>> 8);
         end
      end
   end

   always @(negedge clk) begin
      int x;
      if (e2e && rst_n) begin
         for (int c = 0; c < N; c++) begin
            if (col_out_valid[c]) begin
               checks++;
               if (ps_q[c].size() == 0) begin
                  errors++;
                  $display("FAIL psum_extra col=%0d got %0d exp none",
                           c, ps[N-1][c]);
               end else begin
                  x = ps_q[c].pop_front();
                  if (ps[N-1][c] != x) begin
                     errors++;
                     $display("FAIL psum col=%0d got %0d exp %0d",
                              c, ps[N-1][c], x);
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_abort();
      obs_t a;
      mon_en = 0;
      exp_q.delete();
      #2 rst_n = 1'b0;
      #1;
      a = sample();
      checks++;
      if (a !== idle_obs()) begin
         errors++;
         $display("FAIL async_reset got %h exp %h", a, idle_obs());
      end
      start    = 1'b0;
      num_vecs = '0;
      reuse_w  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 mon_en = 1;
   endtask

   task automatic run(input int m, input bit reuse, input bit hold,
                      input int abort_at);
      int d;
      d        = (reuse ? 1 : N + 4) + m + 2 * N;
      start    = 1'b1;
      reuse_w  = reuse;
      num_vecs = VW'(m);
      for (int t = 0; t <= d; t++) exp_q.push_back(exp_at(t, m, reuse));
      for (int t = 1; t <= d; t++) begin
         @(posedge clk);
         #1;
         if (t == abort_at) begin
            do_abort();
            return;
         end
         if (hold) begin
            start    = 1'b1;
            num_vecs = VW'(m);
         end else begin
            start    = 1'($urandom % 2);
            num_vecs = VW'($urandom_range(0, 5));
            reuse_w  = 1'($urandom % 2);
         end
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      num_vecs = '0;
      reuse_w  = 1'b0;
   endtask

   task automatic idle_gap(input int n);
      repeat (n) begin
         start    = 1'($urandom % 2);
         reuse_w  = 1'($urandom % 2);
         num_vecs = '0;
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      reuse_w = 1'b0;
   endtask

   initial begin
      obs_t a;
      rst_n    = 1'b0;
      start    = 1'b0;
      reuse_w  = 1'b0;
      num_vecs = '0;
      for (int k = 0; k < N; k++)
         for (int c = 0; c < N; c++) wbuf[k][c] = $urandom_range(0, 512);
      for (int v = 0; v < 8; v++)
         for (int c = 0; c < N; c++) ibuf[v][c] = $urandom_range(0, 255);
      repeat (3) @(posedge clk);
      #1;
      a = sample();
      checks++;
      if (a !== idle_obs()) begin
         errors++;
         $display("FAIL reset_state got %h exp %h", a, idle_obs());
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 mon_en = 1;

      idle_gap(4);
      run(3, 1'b0, 1'b1, 0);
      run(3, 1'b0, 1'b0, 0);
      run(2, 1'b1, 1'b0, 0);
      idle_gap(2);
      run(3, 1'b0, 1'b0, 9);
      run(3, 1'b0, 1'b0, 0);

      for (int i = 0; i < 16; i++) begin
         run($urandom_range(1, 6), 1'($urandom % 2), 1'($urandom % 2), 0);
         if ($urandom % 2 == 1) idle_gap($urandom_range(1, 3));
      end

      // identity weights: buffer row k lands in array row N-1-k
      for (int k = 0; k < N; k++)
         for (int c = 0; c < N; c++)
            wbuf[k][c] = (c == N - 1 - k) ? 256 : 0;
      for (int v = 0; v < 3; v++)
         for (int c = 0; c < N; c++) begin
            ibuf[v][c] = $urandom_range(0, 255);
            ps_q[c].push_back(ibuf[v][c]);
         end
      idle_gap(1);
      e2e = 1;
      run(3, 1'b0, 1'b0, 0);
      idle_gap(3);
      e2e = 0;
      for (int c = 0; c < N; c++) begin
         checks++;
         if (ps_q[c].size() != 0) begin
            errors++;
            $display("FAIL psum_missing col=%0d got %0d left exp 0",
                     c, ps_q[c].size());
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
